// File: rtl/block_window_fetch.sv
// Beat-map window fetcher: skips expired records, then burst-reads the next NUM_SLOTS records and
// commits them atomically. Define BLOCK_FETCH_REWIND_EN to rewind head on a backward time jump.
module block_window_fetch #(
    parameter int NUM_SLOTS = 12,
    parameter int ADDR_W    = 10
) (
    input  logic                        clk_in,
    input  logic                        rst_n_in,
    input  logic                        frame_start_in,
    input  logic [17:0]                 curr_time_in,
    input  logic [ADDR_W:0]             num_blocks_in,
    output logic [ADDR_W-1:0]           mem_addr_out,
    input  logic [53:0]                 mem_data_in,
    output logic                        busy_out,
    output logic                        valid_out,
    output logic [17:0]                 curr_time_out,
    output logic [NUM_SLOTS-1:0][11:0]  block_x_out,
    output logic [NUM_SLOTS-1:0][11:0]  block_y_out,
    output logic [NUM_SLOTS-1:0][17:0]  block_time_out,
    output logic [NUM_SLOTS-1:0]        block_color_out,
    output logic [NUM_SLOTS-1:0][2:0]   block_direction_out,
    output logic [NUM_SLOTS-1:0][7:0]   block_ID_out
);

    localparam int REC_W = 54;
    localparam int CNT_W = $clog2(NUM_SLOTS + 2);
    localparam int SUM_W = ADDR_W + 2;
    localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_TWO    = CNT_W'(2);
    localparam logic [CNT_W-1:0]  LAST_ISSUE = CNT_W'(NUM_SLOTS - 1);
    localparam logic [CNT_W-1:0]  LAST_FILL  = CNT_W'(NUM_SLOTS + 1);
    localparam logic [ADDR_W:0]   HEAD_ONE   = (ADDR_W + 1)'(1);
    localparam logic [SUM_W-1:0]  ADDR_MAX   = SUM_W'((1 << ADDR_W) - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SKIP_ISSUE,
        S_SKIP_WAIT,
        S_SKIP_CHECK,
        S_FILL,
        S_COMMIT
    } state_t;

    state_t             state_q, state_d;
    logic [ADDR_W:0]    head_q, head_d;
    logic [17:0]        t_req_q, t_req_d;
    logic [CNT_W-1:0]   fill_cnt_q, fill_cnt_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic               rng_addr_q, rng_addr_d;
    logic [1:0]         rng_pipe_q, rng_pipe_d;
    logic               busy_q, busy_d;
    logic               valid_q, valid_d;
    logic [17:0]        time_out_q, time_out_d;
    logic [REC_W-1:0]   shadow_q [NUM_SLOTS];
    logic [REC_W-1:0]   shadow_d [NUM_SLOTS];
    logic [REC_W-1:0]   win_q    [NUM_SLOTS];
    logic [REC_W-1:0]   win_d    [NUM_SLOTS];

    logic               issue_en;
    logic [ADDR_W:0]    issue_base;
    logic [CNT_W-1:0]   issue_off;
    logic [SUM_W-1:0]   issue_sum;
    logic [CNT_W-1:0]   slot_idx;
    logic               rec_expired;

    assign rec_expired = (head_q < num_blocks_in) && (mem_data_in[41:24] <= t_req_q);
    assign slot_idx    = fill_cnt_q - CNT_TWO;

    // NOTE: every variable gets a default before the case so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        head_d     = head_q;
        t_req_d    = t_req_q;
        fill_cnt_d = fill_cnt_q;
        valid_d    = 1'b0;
        time_out_d = time_out_q;
        shadow_d   = shadow_q;
        win_d      = win_q;
        issue_en   = 1'b0;
        issue_base = head_q;
        issue_off  = '0;

        unique case (state_q)
            S_IDLE: begin
                if (frame_start_in) begin
                    t_req_d = curr_time_in;
`ifdef BLOCK_FETCH_REWIND_EN
                    if (curr_time_in < time_out_q) head_d = '0;
`endif
                    issue_en   = 1'b1;
                    issue_base = head_d;
                    state_d    = S_SKIP_ISSUE;
                end
            end
            S_SKIP_ISSUE: state_d = S_SKIP_WAIT;
            S_SKIP_WAIT:  state_d = S_SKIP_CHECK;
            S_SKIP_CHECK: begin
                issue_en = 1'b1;
                if (rec_expired) begin
                    head_d     = head_q + HEAD_ONE;
                    issue_base = head_d;
                    state_d    = S_SKIP_ISSUE;
                end else begin
                    fill_cnt_d = '0;
                    state_d    = S_FILL;
                end
            end
            S_FILL: begin
                if (fill_cnt_q < LAST_ISSUE) begin
                    issue_en  = 1'b1;
                    issue_off = fill_cnt_q + CNT_ONE;
                end
                // Data lags its address by two cycles; the in-range flag rides the same pipe.
                if (fill_cnt_q >= CNT_TWO) begin
                    shadow_d[slot_idx] = rng_pipe_q[1] ? mem_data_in : '0;
                end
                if (fill_cnt_q == LAST_FILL) state_d = S_COMMIT;
                else                         fill_cnt_d = fill_cnt_q + CNT_ONE;
            end
            S_COMMIT: begin
                win_d      = shadow_q;
                time_out_d = t_req_q;
                valid_d    = 1'b1;
                state_d    = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        issue_sum  = SUM_W'(issue_base) + SUM_W'(issue_off);
        addr_d     = addr_q;
        rng_addr_d = rng_addr_q;
        if (issue_en) begin
            addr_d     = (issue_sum > ADDR_MAX) ? '1 : issue_sum[ADDR_W-1:0];
            rng_addr_d = issue_sum < SUM_W'(num_blocks_in);
        end
        rng_pipe_d = {rng_pipe_q[0], rng_addr_q};
        busy_d     = (state_d != S_IDLE);
    end

    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q    <= S_IDLE;
            head_q     <= '0;
            t_req_q    <= '0;
            fill_cnt_q <= '0;
            addr_q     <= '0;
            rng_addr_q <= 1'b0;
            rng_pipe_q <= '0;
            busy_q     <= 1'b0;
            valid_q    <= 1'b0;
            time_out_q <= '0;
            for (int i = 0; i < NUM_SLOTS; i++) win_q[i] <= '0;
        end else begin
            state_q    <= state_d;
            head_q     <= head_d;
            t_req_q    <= t_req_d;
            fill_cnt_q <= fill_cnt_d;
            addr_q     <= addr_d;
            rng_addr_q <= rng_addr_d;
            rng_pipe_q <= rng_pipe_d;
            busy_q     <= busy_d;
            valid_q    <= valid_d;
            time_out_q <= time_out_d;
            win_q      <= win_d;
        end
    end

    // NOTE: the shadow window needs no reset; every slot is rewritten during FILL before any COMMIT.
    always_ff @(posedge clk_in) begin
        shadow_q <= shadow_d;
    end

    assign mem_addr_out  = addr_q;
    assign busy_out      = busy_q;
    assign valid_out     = valid_q;
    assign curr_time_out = time_out_q;

    always_comb begin
        for (int i = 0; i < NUM_SLOTS; i++) begin
            block_ID_out[i]        = win_q[i][53:46];
            block_direction_out[i] = win_q[i][45:43];
            block_color_out[i]     = win_q[i][42];
            block_time_out[i]      = win_q[i][41:24];
            block_y_out[i]         = win_q[i][23:12];
            block_x_out[i]         = win_q[i][11:0];
        end
    end

endmodule

// File: tb/tb_block_window_fetch.sv
// Self-checking bench for block_window_fetch: 2-cycle BRAM model plus a record-level window model.
module tb_block_window_fetch;

    localparam int NUM_SLOTS = 12;
    localparam int ADDR_W    = 10;
    localparam int DEPTH     = 1 << ADDR_W;
    localparam int TIMEOUT   = 4000;

    logic                        clk = 1'b0;
    logic                        rst_n = 1'b1;
    logic                        frame_start = 1'b0;
    logic [17:0]                 curr_time = '0;
    logic [ADDR_W:0]             num_blocks = '0;
    logic [ADDR_W-1:0]           mem_addr;
    logic [53:0]                 mem_data;
    logic [53:0]                 rd1, rd2;
    logic                        busy_out, valid_out;
    logic [17:0]                 curr_time_out;
    logic [NUM_SLOTS-1:0][11:0]  block_x_out, block_y_out;
    logic [NUM_SLOTS-1:0][17:0]  block_time_out;
    logic [NUM_SLOTS-1:0]        block_color_out;
    logic [NUM_SLOTS-1:0][2:0]   block_direction_out;
    logic [NUM_SLOTS-1:0][7:0]   block_ID_out;

    logic [53:0] mem [DEPTH];
    int          n_vec = 0;
    int          n_err = 0;

    // Reference model state
    int          m_head;
    logic [17:0] m_time;
    logic [53:0] m_slot [NUM_SLOTS];
    int          m_lat;

    block_window_fetch #(.NUM_SLOTS(NUM_SLOTS), .ADDR_W(ADDR_W)) dut (
        .clk_in              (clk),
        .rst_n_in            (rst_n),
        .frame_start_in      (frame_start),
        .curr_time_in        (curr_time),
        .num_blocks_in       (num_blocks),
        .mem_addr_out        (mem_addr),
        .mem_data_in         (mem_data),
        .busy_out            (busy_out),
        .valid_out           (valid_out),
        .curr_time_out       (curr_time_out),
        .block_x_out         (block_x_out),
        .block_y_out         (block_y_out),
        .block_time_out      (block_time_out),
        .block_color_out     (block_color_out),
        .block_direction_out (block_direction_out),
        .block_ID_out        (block_ID_out)
    );

    always #5 clk = ~clk;

    // Two-cycle read latency BRAM
    always @(posedge clk) begin
        rd1 <= mem[mem_addr];
        rd2 <= rd1;
    end
    assign mem_data = rd2;

    function automatic logic [53:0] mk_rec(input logic [17:0] t);
        logic [7:0]  id;
        logic [2:0]  dir;
        logic        col;
        logic [11:0] y, x;
        id  = 8'($urandom);
        dir = 3'($urandom);
        col = 1'($urandom);
        y   = 12'($urandom);
        x   = 12'($urandom);
        return {id, dir, col, t, y, x};
    endfunction

    // Records below n get non-decreasing times; everything above is nonzero junk.
    task automatic fill_mem(input int n, input int base, input int smin, input int smax);
        int t;
        t = base;
        for (int i = 0; i < DEPTH; i++) begin
            if (i < n) begin
                mem[i] = mk_rec(18'(t));
                t += int'($urandom_range(smax, smin));
            end else begin
                mem[i] = {22'($urandom), $urandom} | 54'd1;
            end
        end
        num_blocks = (ADDR_W + 1)'(n);
    endtask

    task automatic model_reset();
        m_head = 0;
        m_time = '0;
        for (int i = 0; i < NUM_SLOTS; i++) m_slot[i] = '0;
    endtask

    task automatic model_frame(input logic [17:0] t);
        int k, nb;
        nb = int'(num_blocks);
`ifdef BLOCK_FETCH_REWIND_EN
        if (t < m_time) m_head = 0;
`endif
        k = 0;
        while (m_head < nb && mem[m_head][41:24] <= t) begin
            m_head++;
            k++;
        end
        m_lat = 3 * (k + 1) + 15;
        for (int i = 0; i < NUM_SLOTS; i++)
            m_slot[i] = (m_head + i < nb) ? mem[m_head + i] : '0;
        m_time = t;
    endtask

    task automatic apply_reset();
        frame_start = 1'b0;
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    // Called #1 after the edge that accepted frame_start; returns in the valid_out cycle.
    task automatic wait_window(input string name);
        int          cyc;
        bit          busy_gap;
        logic [53:0] act;
        cyc = 0;
        busy_gap = 0;
        n_vec++;
        if (busy_out !== 1'b1) begin
            n_err++;
            $display("FAIL %s busy_rise: got %b want 1", name, busy_out);
        end
        while (cyc < TIMEOUT) begin
            @(posedge clk); #1;
            cyc++;
            if (valid_out === 1'b1) break;
            if (busy_out !== 1'b1) busy_gap = 1;
        end
        n_vec++;
        if (valid_out !== 1'b1) begin
            n_err++;
            $display("FAIL %s timeout: no valid_out within %0d cycles", name, TIMEOUT);
            return;
        end
        n_vec++;
        if (cyc != m_lat) begin
            n_err++;
            $display("FAIL %s latency: got %0d want %0d", name, cyc, m_lat);
        end
        n_vec++;
        if (busy_gap || busy_out !== 1'b0) begin
            n_err++;
            $display("FAIL %s busy_shape: gap=%0d busy_at_valid=%b want gap=0 busy=0", name, busy_gap, busy_out);
        end
        n_vec++;
        if (curr_time_out !== m_time) begin
            n_err++;
            $display("FAIL %s curr_time_out: got %0d want %0d", name, curr_time_out, m_time);
        end
        for (int i = 0; i < NUM_SLOTS; i++) begin
            act = {block_ID_out[i], block_direction_out[i], block_color_out[i],
                   block_time_out[i], block_y_out[i], block_x_out[i]};
            n_vec++;
            if (act !== m_slot[i]) begin
                n_err++;
                $display("FAIL %s slot%0d: got %h want %h", name, i, act, m_slot[i]);
            end
        end
    endtask

    task automatic pulse_frame(input logic [17:0] t);
        @(negedge clk);
        curr_time   = t;
        frame_start = 1'b1;
        @(posedge clk); #1;
        frame_start = 1'b0;
    endtask

    task automatic do_frame(input logic [17:0] t, input string name);
        model_frame(t);
        pulse_frame(t);
        wait_window(name);
        @(posedge clk); #1;
        n_vec++;
        if (valid_out !== 1'b0) begin
            n_err++;
            $display("FAIL %s valid_pulse: got %b want 0 after one cycle", name, valid_out);
        end
    endtask

    task automatic test_reset();
        fill_mem(20, 100, 10, 10);
        apply_reset();
        #1;
        n_vec++;
        if (valid_out !== 1'b0 || busy_out !== 1'b0 || mem_addr !== '0) begin
            n_err++;
            $display("FAIL reset_ctrl: valid=%b busy=%b addr=%0d want 0/0/0", valid_out, busy_out, mem_addr);
        end
        n_vec++;
        if ({curr_time_out, block_x_out, block_y_out, block_time_out, block_color_out,
             block_direction_out, block_ID_out} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: got nonzero window, want all 0");
        end
    endtask

    task automatic test_basic_and_skip();
        apply_reset();
        fill_mem(20, 100, 10, 10);
        do_frame(18'd0, "basic_t0");
        n_vec++;
        if (block_time_out[0] !== 18'd100 || block_time_out[11] !== 18'd210) begin
            n_err++;
            $display("FAIL basic_times: got %0d..%0d want 100..210", block_time_out[0], block_time_out[11]);
        end
        do_frame(18'd135, "skip_t135");
        n_vec++;
        if (block_time_out[0] !== 18'd140 || block_time_out[11] !== 18'd250 || m_lat != 30) begin
            n_err++;
            $display("FAIL skip_times: got %0d..%0d want 140..250", block_time_out[0], block_time_out[11]);
        end
    endtask

    task automatic test_partial();
        apply_reset();
        fill_mem(5, 100, 10, 10);
        do_frame(18'd0, "partial_t0");
        n_vec++;
        if (block_time_out[5] !== 18'd0 || block_x_out[11] !== 12'd0 || block_time_out[4] !== 18'd140) begin
            n_err++;
            $display("FAIL partial_tail: t4=%0d t5=%0d want 140/0", block_time_out[4], block_time_out[5]);
        end
        do_frame(18'd1000, "partial_drain");
        do_frame(18'd2000, "partial_head_at_end");
        apply_reset();
        fill_mem(0, 100, 10, 10);
        do_frame(18'd0, "empty_t0");
        do_frame(18'd500, "empty_t500");
    endtask

    task automatic test_drop();
        int cyc, nvalid, first;
        bit busy_gap;
        logic [53:0] act;
        apply_reset();
        fill_mem(20, 100, 10, 10);
        model_frame(18'd0);
        pulse_frame(18'd0);
        cyc = 0; nvalid = 0; first = -1; busy_gap = 0;
        for (int c = 0; c < 60; c++) begin
            @(posedge clk); #1;
            cyc++;
            if (cyc == 2) begin curr_time = 18'd500; frame_start = 1'b1; end
            if (cyc == 3) frame_start = 1'b0;
            if (valid_out === 1'b1) begin
                nvalid++;
                if (first < 0) begin
                    first = cyc;
                    for (int i = 0; i < NUM_SLOTS; i++) begin
                        act = {block_ID_out[i], block_direction_out[i], block_color_out[i],
                               block_time_out[i], block_y_out[i], block_x_out[i]};
                        n_vec++;
                        if (act !== m_slot[i]) begin
                            n_err++;
                            $display("FAIL drop_slot%0d: got %h want %h", i, act, m_slot[i]);
                        end
                    end
                end
            end else if (first < 0 && busy_out !== 1'b1) begin
                busy_gap = 1;
            end
        end
        n_vec++;
        if (nvalid != 1 || first != 18) begin
            n_err++;
            $display("FAIL drop_single_valid: got %0d pulses first@%0d want 1 @18", nvalid, first);
        end
        n_vec++;
        if (busy_gap) begin
            n_err++;
            $display("FAIL drop_busy_continuous: got gap want none");
        end
        n_vec++;
        if (curr_time_out !== 18'd0) begin
            n_err++;
            $display("FAIL drop_time: got %0d want 0", curr_time_out);
        end
    endtask

    task automatic test_back_to_back();
        apply_reset();
        fill_mem(20, 100, 10, 10);
        model_frame(18'd0);
        pulse_frame(18'd0);
        wait_window("b2b_first");
        curr_time   = 18'd135;
        frame_start = 1'b1;
        model_frame(18'd135);
        @(posedge clk); #1;
        frame_start = 1'b0;
        wait_window("b2b_second");
    endtask

    task automatic test_reset_mid_fill();
        apply_reset();
        fill_mem(20, 100, 10, 10);
        do_frame(18'd0, "midfill_pre");
        pulse_frame(18'd135);
        repeat (20) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_vec++;
        if (valid_out !== 1'b0 || busy_out !== 1'b0 || mem_addr !== '0) begin
            n_err++;
            $display("FAIL midfill_ctrl: valid=%b busy=%b addr=%0d want 0/0/0", valid_out, busy_out, mem_addr);
        end
        n_vec++;
        if ({curr_time_out, block_x_out, block_y_out, block_time_out, block_color_out,
             block_direction_out, block_ID_out} !== '0) begin
            n_err++;
            $display("FAIL midfill_outputs: got nonzero window, want all 0");
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        do_frame(18'd0, "midfill_reload");
        n_vec++;
        if (block_time_out[0] !== 18'd100) begin
            n_err++;
            $display("FAIL midfill_head0: got %0d want 100", block_time_out[0]);
        end
    endtask

    task automatic test_rewind();
        logic [17:0] want;
        apply_reset();
        fill_mem(20, 100, 10, 10);
        do_frame(18'd200, "rewind_t200");
        do_frame(18'd50, "rewind_t50");
`ifdef BLOCK_FETCH_REWIND_EN
        want = 18'd100;
`else
        want = 18'd210;
`endif
        n_vec++;
        if (block_time_out[0] !== want) begin
            n_err++;
            $display("FAIL rewind_slot0: got %0d want %0d", block_time_out[0], want);
        end
    endtask

    task automatic test_random();
        int          n;
        logic [17:0] t;
        for (int r = 0; r < 4; r++) begin
            apply_reset();
            n = int'($urandom_range(60, 0));
            fill_mem(n, int'($urandom_range(200, 0)), 0, 20);
            t = '0;
            for (int f = 0; f < 6; f++) begin
                if ($urandom_range(4, 0) == 0) t = 18'($urandom_range(int'(t), 0));
                else                           t = t + 18'($urandom_range(80, 0));
                do_frame(t, $sformatf("rand%0d_f%0d", r, f));
            end
        end
    endtask

    task automatic test_saturation();
        apply_reset();
        fill_mem(DEPTH, 1, 1, 1);
        do_frame(18'd1014, "sat_near_end");
        do_frame(18'd5000, "sat_drained");
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = '0;
        model_reset();
        test_reset();
        test_basic_and_skip();
        test_partial();
        test_drop();
        test_back_to_back();
        test_reset_mid_fill();
        test_rewind();
        test_random();
        test_saturation();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
